// File: rtl/axis_frame_buffer.sv
// ---------------------------------------------------------------------------
// axis_frame_buffer
//
// Store-and-forward AXI-stream frame buffer placed in front of the sorter.
// A complete input frame is captured into an internal register array and
// only then replayed, so the sorter always sees a whole frame of at most
// 2^ADDRESS words in contiguous beats. Frames longer than the buffer are
// truncated to DEPTH words and flagged with a one-cycle overflow pulse.
//
// Optional build macro:
//   AXIS_FB_DROP_OVERSIZE_EN - when defined, an oversize frame is dropped
//                              entirely instead of being truncated; overflow
//                              still pulses and frame_len is left unchanged.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   tdata      input stream data (WIDTH bits)
//   tvalid     input beat valid
//   tlast      last beat of input frame
//   tready     block can accept an input beat
//   odata      output stream data (WIDTH bits)
//   ovalid     output beat valid
//   olast      last beat of output frame
//   oready     downstream accepts the output beat
//   frame_len  length of the frame held/draining (ADDRESS+1 bits, 1..DEPTH)
//   overflow   one-cycle pulse when an oversize frame is detected
// ---------------------------------------------------------------------------
module axis_frame_buffer #(
  parameter int WIDTH   = 16,
  parameter int ADDRESS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   tdata,
  input  logic               tvalid,
  input  logic               tlast,
  output logic               tready,
  output logic [WIDTH-1:0]   odata,
  output logic               ovalid,
  output logic               olast,
  input  logic               oready,
  output logic [ADDRESS:0]   frame_len,
  output logic               overflow
);

  localparam int DEPTH = 1 << ADDRESS;
  localparam logic [ADDRESS:0] CNT_ONE   = (ADDRESS+1)'(1);
  localparam logic [ADDRESS:0] CNT_FULL  = (ADDRESS+1)'(DEPTH);
  localparam logic [ADDRESS:0] CNT_LASTW = (ADDRESS+1)'(DEPTH-1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DISCARD = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ADDRESS:0]   wr_cnt, wr_cnt_nxt;
  logic [ADDRESS:0]   rd_cnt, rd_cnt_nxt;
  logic [ADDRESS:0]   len, len_nxt;
  logic [ADDRESS:0]   len_m1;
  logic               overflow_nxt;
  logic               mem_we;
  logic               tready_c;
  logic               ovalid_c;
  logic [WIDTH-1:0]   rd_word;

  // Data storage: deliberately not reset, only the control path is.
  logic [WIDTH-1:0]   mem [DEPTH];

  assign len_m1  = len - CNT_ONE;
  assign rd_word = mem[rd_cnt[ADDRESS-1:0]];

  // --- control state registers ---------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FILL;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      len      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_cnt   <= wr_cnt_nxt;
      rd_cnt   <= rd_cnt_nxt;
      len      <= len_nxt;
      overflow <= overflow_nxt;
    end
  end

  // --- buffer write port ---------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_cnt[ADDRESS-1:0]] <= tdata;
    end
  end

  // --- next-state and stream handshake logic --------------------------------
  always_comb begin
    state_nxt    = state;
    wr_cnt_nxt   = wr_cnt;
    rd_cnt_nxt   = rd_cnt;
    len_nxt      = len;
    overflow_nxt = 1'b0;
    mem_we       = 1'b0;
    tready_c     = 1'b0;
    ovalid_c     = 1'b0;

    case (state)
      FILL: begin
        tready_c = 1'b1;
        if (tvalid) begin
          mem_we     = 1'b1;
          wr_cnt_nxt = wr_cnt + CNT_ONE;
          if (tlast) begin
            // tlast on the DEPTH-th word lands here: a legal full frame.
            len_nxt   = wr_cnt + CNT_ONE;
            state_nxt = DRAIN;
          end else if (wr_cnt == CNT_LASTW) begin
            // Buffer is full and the frame keeps going: flag and discard
            // the rest. wr_cnt parks at DEPTH; it is never used to write
            // from DISCARD, so it cannot wrap onto stored words.
`ifndef AXIS_FB_DROP_OVERSIZE_EN
            len_nxt      = CNT_FULL;
`endif
            overflow_nxt = 1'b1;
            state_nxt    = DISCARD;
          end
        end
      end

      DISCARD: begin
        tready_c = 1'b1;
        if (tvalid && tlast) begin
`ifdef AXIS_FB_DROP_OVERSIZE_EN
          wr_cnt_nxt = '0;
          rd_cnt_nxt = '0;
          state_nxt  = FILL;
`else
          state_nxt  = DRAIN;
`endif
        end
      end

      DRAIN: begin
        ovalid_c = 1'b1;
        if (oready) begin
          if (rd_cnt == len_m1) begin
            rd_cnt_nxt = '0;
            wr_cnt_nxt = '0;
            state_nxt  = FILL;
          end else begin
            rd_cnt_nxt = rd_cnt + CNT_ONE;
          end
        end
      end

      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Outputs are decoded from registered state only, so they hold steady
  // while oready is low. tready is also gated by reset itself so the block
  // refuses beats for the whole time reset is asserted.
  assign tready    = tready_c & ~reset;
  assign ovalid    = ovalid_c;
  assign olast     = ovalid_c & (rd_cnt == len_m1);
  assign odata     = ovalid_c ? rd_word : '0;
  assign frame_len = len;

endmodule

// File: tb/tb_axis_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_buffer
//
// Directed bench for axis_frame_buffer: short, full, oversize, backpressured,
// single-word and reset-interrupted frames with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_axis_frame_buffer;

  localparam int WIDTH   = 16;
  localparam int ADDRESS = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [WIDTH-1:0]   tdata;
  logic               tvalid;
  logic               tlast;
  logic               tready;
  logic [WIDTH-1:0]   odata;
  logic               ovalid;
  logic               olast;
  logic               oready;
  logic [ADDRESS:0]   frame_len;
  logic               overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] vec [0:31];
  int          vlen;

  always #5 clk = ~clk;

  axis_frame_buffer #(
    .WIDTH   (WIDTH),
    .ADDRESS (ADDRESS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tdata     (tdata),
    .tvalid    (tvalid),
    .tlast     (tlast),
    .tready    (tready),
    .odata     (odata),
    .ovalid    (ovalid),
    .olast     (olast),
    .oready    (oready),
    .frame_len (frame_len),
    .overflow  (overflow)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present vec[0..vlen-1] one beat per cycle, tlast on the final word.
  // Called and returns at #1 after a rising edge.
  task automatic send_frame();
    for (int i = 0; i < vlen; i++) begin
      tdata  = vec[i];
      tvalid = 1'b1;
      tlast  = (i == vlen - 1);
      check_val("tready_in", tready, 1);
      check_val("ovalid_in", ovalid, 0);
      @(posedge clk);
      #1;
      check_val("overflow", overflow, (vlen > 16 && i == 15));
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
  endtask

  // Expect vec[0..n-1] with oready held high.
  task automatic drain_frame(input int n);
    for (int i = 0; i < n; i++) begin
      check_val("ovalid", ovalid, 1);
      check_val("odata", odata, vec[i]);
      check_val("olast", olast, (i == n - 1));
      check_val("tready_drain", tready, 0);
      @(posedge clk);
      #1;
    end
    check_val("ovalid_done", ovalid, 0);
    check_val("tready_done", tready, 1);
  endtask

  // Expect vec[0..n-1] with random oready; words must hold while stalled.
  task automatic drain_bp(input int n);
    int idx;
    idx = 0;
    for (int cyc = 0; cyc < 300 && idx < n; cyc++) begin
      oready = 1'($urandom_range(0, 1));
      check_val("bp_ovalid", ovalid, 1);
      check_val("bp_odata", odata, vec[idx]);
      check_val("bp_olast", olast, (idx == n - 1));
      @(posedge clk);
      #1;
      if (oready) idx++;
    end
    check_val("bp_count", idx, n);
    oready = 1'b1;
    check_val("bp_ovalid_done", ovalid, 0);
    check_val("bp_tready_done", tready, 1);
  endtask

  initial begin
    reset  = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    oready = 1'b1;
    #2;
    check_val("rst_tready", tready, 0);
    check_val("rst_ovalid", ovalid, 0);
    check_val("rst_olast", olast, 0);
    check_val("rst_odata", odata, 0);
    check_val("rst_frame_len", frame_len, 0);
    check_val("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_val("post_rst_tready", tready, 1);
    @(posedge clk);
    #1;

    // Five-word frame
    vec[0] = 16'd9; vec[1] = 16'd3; vec[2] = 16'd7; vec[3] = 16'd1; vec[4] = 16'd5;
    vlen = 5;
    send_frame();
    check_val("len5", frame_len, 5);
    drain_frame(5);

    // Exact full frame 0..15
    for (int i = 0; i < 16; i++) vec[i] = 16'(i);
    vlen = 16;
    send_frame();
    check_val("len16", frame_len, 16);
    drain_frame(16);

    // Oversize frame 100..119
    for (int i = 0; i < 20; i++) vec[i] = 16'(100 + i);
    vlen = 20;
    send_frame();
`ifdef AXIS_FB_DROP_OVERSIZE_EN
    check_val("drop_ovalid", ovalid, 0);
    check_val("drop_tready", tready, 1);
    check_val("drop_len_kept", frame_len, 16);
    @(posedge clk);
    #1;
    check_val("drop_ovalid_later", ovalid, 0);
`else
    check_val("len_trunc", frame_len, 16);
    drain_frame(16);
`endif

    // Seven-word frame with backpressure
    for (int i = 0; i < 7; i++) vec[i] = 16'(16'h0A00 + 16'(i * 3));
    vlen = 7;
    send_frame();
    check_val("len7", frame_len, 7);
    drain_bp(7);

    // Single-word frame
    vec[0] = 16'hBEEF;
    vlen = 1;
    send_frame();
    check_val("len1", frame_len, 1);
    drain_frame(1);

    // Reset in the middle of a drain
    for (int i = 0; i < 6; i++) vec[i] = 16'(21 + i);
    vlen = 6;
    send_frame();
    for (int i = 0; i < 2; i++) begin
      check_val("pre_rst_odata", odata, vec[i]);
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_ovalid", ovalid, 0);
    check_val("mid_rst_tready", tready, 0);
    check_val("mid_rst_odata", odata, 0);
    check_val("mid_rst_len", frame_len, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("after_rst_ovalid", ovalid, 0);
    vec[0] = 16'd31; vec[1] = 16'd32; vec[2] = 16'd33;
    vlen = 3;
    send_frame();
    check_val("len3", frame_len, 3);
    drain_frame(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
